rr_merge_arbiter: RTL

- Round-robin arbiter that shares one downstream valid/bp consumer among NumInputs upstream producers.
- Dual of the fork primitives: N latency-insensitive channels merge into one channel, with fairness and grant locking.
- Data passes through combinationally (zero latency). Sequential state is the round-robin pointer and the grant lock.

---
 rtl/rr_merge_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_merge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_merge_arbiter
//  Description : Round-robin merge of NumInputs valid/bp producer channels
//                onto a single valid/bp consumer channel. Data is muxed
//                through combinationally (zero latency). A grant issued
//                while the consumer stalls is locked until it transfers.
//  Ports       : clk        - clock
//                resetn     - synchronous reset, active low
//                din        - packed producer data, channel i at [i*Width +: Width]
//                din_valid  - per-producer valid
//                din_bp     - per-producer backpressure (1 = not accepted)
//                dout       - data of the granted producer
//                dout_valid - merged valid
//                dout_bp    - consumer backpressure
//                dout_sel   - index of the granted producer
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_merge_arbiter #(
    parameter int Width     = 8,
    parameter int NumInputs = 4,
    parameter int SelWidth  = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NumInputs*Width-1:0] din,
    input  logic [NumInputs-1:0]       din_valid,
    output logic [NumInputs-1:0]       din_bp,
    output logic [Width-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_bp,
    output logic [SelWidth-1:0]        dout_sel
);

    localparam logic [SelWidth-1:0] c_last_idx = SelWidth'(NumInputs - 1);
    localparam logic [SelWidth:0]   c_num_in   = (SelWidth + 1)'(NumInputs);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SelWidth-1:0] ptr_q, ptr_d;
    logic [SelWidth-1:0] lock_idx_q, lock_idx_d;

    logic [SelWidth-1:0] w_search_idx;
    logic                w_search_hit;
    logic                w_lock_hold;
    logic [SelWidth-1:0] w_grant;
    logic                w_grant_vld;

    // Rotating priority search starting at ptr_q. Offsets are scanned from
    // the farthest to the nearest so the nearest valid channel is the one
    // left standing. The index is kept below NumInputs by a single
    // conditional subtract, which never overflows the extra sum bit.
    always_comb begin : p_search
        logic [SelWidth:0]   v_sum;
        logic [SelWidth-1:0] v_idx;
        w_search_idx = ptr_q;
        w_search_hit = 1'b0;
        v_sum        = '0;
        v_idx        = '0;
        for (int k = NumInputs - 1; k >= 0; k--) begin
            v_sum = {1'b0, ptr_q} + (SelWidth + 1)'(k);
            if (v_sum >= c_num_in) begin
                v_sum = v_sum - c_num_in;
            end
            v_idx = v_sum[SelWidth-1:0];
            if (din_valid[v_idx]) begin
                w_search_idx = v_idx;
                w_search_hit = 1'b1;
            end
        end
    end

    // A locked grant is only honoured while its producer still holds valid;
    // otherwise the normal search takes over in the same cycle.
    always_comb begin : p_grant
        w_lock_hold = (state_q == ST_LOCKED) && din_valid[lock_idx_q];
        w_grant     = w_lock_hold ? lock_idx_q : w_search_idx;
        w_grant_vld = w_lock_hold || w_search_hit;
    end

    // Outputs are forced to a quiet state while reset is held.
    always_comb begin : p_outputs
        dout       = din[Width-1:0];
        dout_valid = 1'b0;
        dout_sel   = '0;
        din_bp     = '1;
        if (resetn) begin
            dout_valid = w_grant_vld;
            dout_sel   = w_grant;
            for (int i = 0; i < NumInputs; i++) begin
                if (w_grant == SelWidth'(i)) begin
                    dout = din[i*Width +: Width];
                end
                din_bp[i] = !((w_grant == SelWidth'(i)) && w_grant_vld && !dout_bp);
            end
        end
    end

    always_comb begin : p_next_state
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (w_grant_vld && !dout_bp) begin
            // Transfer: advance the pointer past the winner.
            state_d = ST_IDLE;
            ptr_d   = (w_grant == c_last_idx) ? '0 : w_grant + SelWidth'(1);
        end else if (w_grant_vld) begin
            // Stalled: pin the grant so dout/dout_sel cannot move.
            state_d    = ST_LOCKED;
            lock_idx_d = w_grant;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule
`default_nettype wire
